// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-master Wishbone ROM arbiter.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // The round-robin pointer always names the master that lost (or did not take) the last grant.
   function automatic logic other_master(input logic m);
      return ~m;
   endfunction

endpackage

// File: rtl/rom_arb_timeout.sv
// Grant watchdog: counts grant cycles without an ack and flags expiry on the CYCLES-th one.
module rom_arb_timeout #(
   parameter int unsigned CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned Last = (CYCLES == 0) ? 0 : CYCLES - 1;
   localparam int unsigned CntW = (Last < 2) ? 1 : $clog2(Last + 1);

   logic [CntW-1:0] count_q, count_d;
   logic            at_last;

   assign at_last = (count_q == CntW'(Last));
   // Expiry is combinational so the error pulse lands in the same cycle the limit is reached.
   assign expired = enable && at_last;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !at_last) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rom_arbiter_wb.sv
// Round-robin arbiter giving two Wishbone masters single-transfer access to one ROM slave.
// Optional grant watchdog enabled by defining ROM_ARB_TIMEOUT_EN.
module rom_arbiter_wb
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADR_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   output logic [31:0]      m0_dat_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic [31:0]      m1_dat_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i
);

   arb_state_e state_q, state_d;
   logic       rr_q, rr_d;
   logic       req0, req1;
   logic       grant_start;
   logic       in_grant;
   logic       timeout_expired;

   assign req0     = m0_cyc_i && m0_stb_i;
   assign req1     = m1_cyc_i && m1_stb_i;
   assign in_grant = (state_q != IDLE);

`ifdef ROM_ARB_TIMEOUT_EN
   rom_arb_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (grant_start),
      .enable  (in_grant && !wbm_ack_i),
      .expired (timeout_expired)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_expired    = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      grant_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 && (!req1 || rr_q == M0)) begin
               state_d     = GNT0;
               rr_d        = other_master(M0);
               grant_start = 1'b1;
            end else if (req1) begin
               state_d     = GNT1;
               rr_d        = other_master(M1);
               grant_start = 1'b1;
            end
         end
         // One transfer per grant: ack, abort or watchdog expiry all hand back to IDLE.
         GNT0: begin
            if (!req0 || wbm_ack_i || timeout_expired) begin
               state_d = IDLE;
            end
         end
         GNT1: begin
            if (!req1 || wbm_ack_i || timeout_expired) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= M0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Slave-side muxing is purely a function of the registered owner, so reset zeroes it at once.
   always_comb begin
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_adr_o = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m0_dat_o  = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      m1_dat_o  = '0;
      unique case (state_q)
         GNT0: begin
            wbm_cyc_o = m0_cyc_i;
            wbm_stb_o = m0_stb_i;
            wbm_adr_o = m0_adr_i;
            m0_ack_o  = wbm_ack_i;
            m0_dat_o  = wbm_dat_i;
            m0_err_o  = timeout_expired;
         end
         GNT1: begin
            wbm_cyc_o = m1_cyc_i;
            wbm_stb_o = m1_stb_i;
            wbm_adr_o = m1_adr_i;
            m1_ack_o  = wbm_ack_i;
            m1_dat_o  = wbm_dat_i;
            m1_err_o  = timeout_expired;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rom_arbiter_wb.sv
// Self-checking bench for rom_arbiter_wb: directed scenarios plus a randomized two-master run.
module tb_rom_arbiter_wb;

   localparam int unsigned ADR_W = 32;
`ifdef ROM_ARB_TIMEOUT_EN
   localparam int unsigned TMO = 4;
`else
   localparam int unsigned TMO = 16;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
   logic [ADR_W-1:0] m0_adr_i, m1_adr_i;
   logic             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0]      m0_dat_o, m1_dat_o;
   logic             wbm_cyc_o, wbm_stb_o, wbm_ack_i;
   logic [ADR_W-1:0] wbm_adr_o;
   logic [31:0]      wbm_dat_i;

   always #5 clk = ~clk;

   rom_arbiter_wb #(
      .ADR_W          (ADR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_cyc_i  (m0_cyc_i),
      .m0_stb_i  (m0_stb_i),
      .m0_adr_i  (m0_adr_i),
      .m0_ack_o  (m0_ack_o),
      .m0_err_o  (m0_err_o),
      .m0_dat_o  (m0_dat_o),
      .m1_cyc_i  (m1_cyc_i),
      .m1_stb_i  (m1_stb_i),
      .m1_adr_i  (m1_adr_i),
      .m1_ack_o  (m1_ack_o),
      .m1_err_o  (m1_err_o),
      .m1_dat_o  (m1_dat_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_dat_i (wbm_dat_i)
   );

   // ROM slave: registered one-cycle response, ack can be suppressed or forced from the bench.
   logic [31:0] rom [0:63];
   logic        rom_ack_q = 1'b0;
   logic [31:0] rom_dat_q = '0;
   logic        ack_en, stray_ack;

   always @(posedge clk) begin
      rom_ack_q <= wbm_cyc_o & wbm_stb_o & ~rom_ack_q & ack_en;
      rom_dat_q <= rom[wbm_adr_o[7:2]];
   end
   assign wbm_ack_i = rom_ack_q | stray_ack;
   assign wbm_dat_i = rom_dat_q;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drv0(input logic req, input logic [31:0] adr);
      m0_cyc_i = req;
      m0_stb_i = req;
      m0_adr_i = adr;
   endtask

   task automatic drv1(input logic req, input logic [31:0] adr);
      m1_cyc_i = req;
      m1_stb_i = req;
      m1_adr_i = adr;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_ctl"}, 64'({wbm_cyc_o, wbm_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 0);
      chk({tag, "_adr"}, 64'(wbm_adr_o), 0);
      chk({tag, "_dat"}, {m0_dat_o, m1_dat_o}, 0);
   endtask

   int          issued [2];
   int          done   [2];
   int          waitc  [2];
   logic        want   [2];
   logic [31:0] radr   [2];
   logic        acks   [2];
   logic [31:0] dats   [2];

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h1;
      rst_n     = 1'b0;
      ack_en    = 1'b1;
      stray_ack = 1'b1;
      drv0(1'b1, 32'h10);
      drv1(1'b1, 32'h20);

      // Outputs stay zero while reset is held, even with requests and a stray ack present.
      tick(); sample();
      check_quiet("reset_hold");
      tick(); tick();
      drv0(1'b0, 0); drv1(1'b0, 0);
      stray_ack = 1'b0;
      rst_n     = 1'b1;
      sample();
      check_quiet("after_release");

      // Tie straight after reset: m0 first, then m1.
      tick(); drv0(1'b1, 32'h30); drv1(1'b1, 32'h20); sample();
      chk("tie_c0_no_stb", 64'(wbm_stb_o), 0);
      tick(); sample();
      chk("tie_c1_stb", 64'(wbm_stb_o), 1);
      chk("tie_c1_m0_adr", 64'(wbm_adr_o), 64'h30);
      tick(); sample();
      chk("tie_c2_m0_ack", 64'(m0_ack_o), 1);
      chk("tie_c2_m0_dat", 64'(m0_dat_o), 64'(rom[12]));
      chk("tie_c2_m1_quiet", 64'({m1_ack_o, m1_dat_o}), 0);
      tick(); drv0(1'b0, 0); sample();
      chk("tie_c3_idle", 64'(wbm_stb_o), 0);
      tick(); sample();
      chk("tie_c4_m1_adr", 64'(wbm_adr_o), 64'h20);
      tick(); sample();
      chk("tie_c5_m1_ack", 64'(m1_ack_o), 1);
      chk("tie_c5_m1_dat", 64'(m1_dat_o), 64'(rom[8]));
      chk("tie_c5_m0_quiet", 64'({m0_ack_o, m0_dat_o}), 0);
      tick(); drv1(1'b0, 0); sample();

      // Second tie goes to m0 again.
      tick(); drv0(1'b1, 32'h44); drv1(1'b1, 32'h48); sample();
      tick(); sample();
      chk("tie2_m0_first", 64'(wbm_adr_o), 64'h44);
      tick(); sample();
      chk("tie2_m0_ack", 64'(m0_ack_o), 1);
      tick(); drv0(1'b0, 0); sample();
      tick(); sample();
      chk("tie2_m1_next", 64'(wbm_adr_o), 64'h48);
      tick(); sample();
      chk("tie2_m1_dat", 64'({m1_ack_o, m1_dat_o}), 64'({1'b1, rom[18]}));
      tick(); drv1(1'b0, 0); sample();

      // Single m0 read of 0x10.
      tick(); drv0(1'b1, 32'h10); sample();
      chk("single_c0_no_stb", 64'(wbm_stb_o), 0);
      tick(); sample();
      chk("single_c1_stb_adr", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 32'h10}));
      chk("single_c1_no_ack", 64'(m0_ack_o), 0);
      tick(); sample();
      chk("single_c2_ack_dat", 64'({m0_ack_o, m0_dat_o}), 64'({1'b1, rom[4]}));
      chk("single_c2_m1_ack", 64'(m1_ack_o), 0);
      tick(); drv0(1'b0, 0); sample();
      chk("single_c3_no_ack", 64'(m0_ack_o), 0);

      // m1 request arrives during an m0 grant and is held until served.
      tick(); drv0(1'b1, 32'h28); sample();
      tick(); drv1(1'b1, 32'h2C); sample();
      chk("pend_m0_owner", 64'(wbm_adr_o), 64'h28);
      tick(); sample();
      chk("pend_m0_ack", 64'({m0_ack_o, m1_ack_o}), 64'b10);
      tick(); drv0(1'b0, 0); sample();
      chk("pend_idle", 64'(wbm_stb_o), 0);
      tick(); sample();
      chk("pend_m1_grant", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 32'h2C}));
      tick(); sample();
      chk("pend_m1_ack", 64'({m1_ack_o, m1_dat_o}), 64'({1'b1, rom[11]}));
      tick(); drv1(1'b0, 0); sample();

      // Reset while m1 owns the bus with its strobe pending.
      tick(); drv1(1'b1, 32'h24); sample();
      tick(); sample();
      chk("rst_pre_grant", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 32'h24}));
      rst_n = 1'b0; stray_ack = 1'b1; #1;
      check_quiet("rst_same_cycle");
      tick(); sample();
      check_quiet("rst_held");
      tick(); rst_n = 1'b1; sample();
      chk("rst_release_idle", 64'({wbm_stb_o, m1_ack_o}), 0);
      tick(); stray_ack = 1'b0; sample();
      chk("rst_first_grant", 64'({wbm_stb_o, wbm_adr_o, m1_ack_o}), 64'({1'b1, 32'h24, 1'b0}));
      tick(); sample();
      chk("rst_m1_ack", 64'({m1_ack_o, m1_dat_o}), 64'({1'b1, rom[9]}));
      tick(); drv1(1'b0, 0); sample();

`ifdef ROM_ARB_TIMEOUT_EN
      // Silent ROM: m0 gets one err pulse in the 4th grant cycle, then pending m1 is served.
      ack_en = 1'b0;
      tick(); drv0(1'b1, 32'h14); sample();
      tick(); drv1(1'b1, 32'h18); sample();
      chk("tmo_g1", 64'({wbm_stb_o, m0_err_o}), 64'b10);
      tick(); sample();
      chk("tmo_g2", 64'({wbm_stb_o, m0_err_o}), 64'b10);
      tick(); sample();
      chk("tmo_g3", 64'({wbm_stb_o, m0_err_o}), 64'b10);
      tick(); sample();
      chk("tmo_g4_err", 64'({m0_err_o, m1_err_o, m0_ack_o}), 64'b100);
      tick(); drv0(1'b0, 0); ack_en = 1'b1; sample();
      chk("tmo_after_err", 64'({m0_err_o, wbm_stb_o}), 0);
      tick(); sample();
      chk("tmo_m1_grant", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 32'h18}));
      tick(); sample();
      chk("tmo_m1_ack", 64'({m1_ack_o, m1_err_o}), 64'b10);
      tick(); drv1(1'b0, 0); sample();
`else
      // Silent ROM without the watchdog: the grant is held and no error ever appears.
      ack_en = 1'b0;
      tick(); drv0(1'b1, 32'h14); sample();
      for (int i = 0; i < 50; i++) begin
         tick(); sample();
         chk("hold_grant", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, 32'h14}));
         chk("hold_no_err_ack", 64'({m0_err_o, m1_err_o, m0_ack_o}), 0);
      end
      tick(); drv0(1'b0, 0); sample();
      chk("abort_no_cyc", 64'({wbm_cyc_o, m0_ack_o}), 0);
      tick(); ack_en = 1'b1; sample();
      chk("abort_idle", 64'({wbm_stb_o, m0_err_o}), 0);
`endif

      // Random interleaving: every held request must be served within 5 cycles with correct data.
      for (int m = 0; m < 2; m++) begin
         issued[m] = 0; done[m] = 0; waitc[m] = 0; want[m] = 1'b0; radr[m] = '0;
      end
      for (int n = 0; n < 4000; n++) begin
         if (issued[0] + issued[1] == 100 && !want[0] && !want[1]) break;
         tick();
         for (int m = 0; m < 2; m++) begin
            if (!want[m] && issued[0] + issued[1] < 100 && $urandom_range(0, 2) == 0) begin
               want[m]  = 1'b1;
               radr[m]  = 32'($urandom_range(0, 63)) << 2;
               waitc[m] = 0;
               issued[m]++;
            end
         end
         drv0(want[0], radr[0]);
         drv1(want[1], radr[1]);
         sample();
         acks[0] = m0_ack_o; acks[1] = m1_ack_o;
         dats[0] = m0_dat_o; dats[1] = m1_dat_o;
         chk("rand_ack_exclusive", 64'(m0_ack_o & m1_ack_o), 0);
         if (wbm_stb_o) begin
            chk("rand_wbm_adr_owner",
                64'((want[0] && wbm_adr_o == radr[0]) || (want[1] && wbm_adr_o == radr[1])), 1);
         end
         for (int m = 0; m < 2; m++) begin
            if (acks[m]) begin
               chk("rand_ack_has_req", 64'(want[m]), 1);
               chk("rand_data", 64'(dats[m]), 64'(rom[radr[m][7:2]]));
               chk("rand_latency", 64'(waitc[m] <= 5), 1);
               want[m] = 1'b0;
               done[m]++;
            end else if (want[m]) begin
               waitc[m]++;
            end
         end
      end
      chk("rand_all_served", 64'(done[0] + done[1]), 100);
      chk("rand_m0_balance", 64'(done[0]), 64'(issued[0]));
      chk("rand_m1_balance", 64'(done[1]), 64'(issued[1]));
      tick(); drv0(1'b0, 0); drv1(1'b0, 0); sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
